// File: rtl/acker_pkg.sv
// Shared constants for the ADC sample buffer: sensor tags, field widths, entry width.
// The timestamp field only exists in builds that define ACKER_TIMESTAMP_EN.
package acker_pkg;

    localparam int ACKER_DATA_W     = 14;
    localparam int ACKER_SENSOR_W   = 2;
    localparam int ACKER_TS_W       = 16;
    localparam int ACKER_DEPTH_LOG2 = 4;

`ifdef ACKER_TIMESTAMP_EN
    localparam bit ACKER_TS_EN = 1'b1;
`else
    localparam bit ACKER_TS_EN = 1'b0;
`endif

    typedef logic [ACKER_SENSOR_W-1:0] sensor_t;

    localparam sensor_t SENSOR_0 = 2'b00;
    localparam sensor_t SENSOR_1 = 2'b01;
    localparam sensor_t SENSOR_2 = 2'b10;
    localparam sensor_t SENSOR_3 = 2'b11;

    // Stored entry layout, MSB first: {sensor, data[, timestamp]}
    function automatic int entry_w(input int data_w, input int ts_w);
        return data_w + ACKER_SENSOR_W + (ACKER_TS_EN ? ts_w : 0);
    endfunction

endpackage

// File: rtl/acker_data_access_if.sv
// Sample-in handshake, configuration and host read port of the sample buffer.
// slave = the buffer itself, master = ADC controller / host side.
interface acker_data_access_if #(
    parameter int DATA_W     = 14,
    parameter int DEPTH_LOG2 = 4,
    parameter int TS_W       = 16
);
    logic [DATA_W-1:0]   da_Data_in;
    logic                da_Data_in_valid;
    logic [1:0]          da_sensor_type;
    logic                da_Ready_for_Data_in;
    logic [3:0]          sensor_mask;
    logic                flush;
    logic                rd_req;
    logic                rd_valid;
    logic [DATA_W-1:0]   rd_data;
    logic [1:0]          rd_sensor;
    logic [TS_W-1:0]     rd_timestamp;
    logic                rd_underflow;
    logic [DEPTH_LOG2:0] fill_level;
    logic [15:0]         discard_count;

    modport slave (
        input  da_Data_in, da_Data_in_valid, da_sensor_type, sensor_mask, flush, rd_req,
        output da_Ready_for_Data_in, rd_valid, rd_data, rd_sensor, rd_timestamp,
               rd_underflow, fill_level, discard_count
    );

    modport master (
        output da_Data_in, da_Data_in_valid, da_sensor_type, sensor_mask, flush, rd_req,
        input  da_Ready_for_Data_in, rd_valid, rd_data, rd_sensor, rd_timestamp,
               rd_underflow, fill_level, discard_count
    );
endinterface

// File: rtl/acker_fifo_mem.sv
// Register-array storage for the sample FIFO: one write port, one registered read port.
// Read data appears the cycle after i_rd_en and holds until the next read; no backpressure.
module acker_fifo_mem #(
    parameter int WIDTH      = 16,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  i_wr_en,
    input  logic [DEPTH_LOG2-1:0] i_wr_addr,
    input  logic [WIDTH-1:0]      i_wr_dat,
    input  logic                  i_rd_en,
    input  logic [DEPTH_LOG2-1:0] i_rd_addr,
    output logic [WIDTH-1:0]      o_rd_dat
);
    logic [WIDTH-1:0] r_mem [2**DEPTH_LOG2];
    logic [WIDTH-1:0] r_rd_dat;

    always_ff @(posedge clock) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_dat;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rd_dat <= '0;
        end else if (i_rd_en) begin
            r_rd_dat <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_dat = r_rd_dat;
endmodule

// File: rtl/acker_data_access.sv
// ADC sample buffer: mask-filtered FIFO with 1-cycle request/valid readout; ready drops only when full.
// ACKER_TIMESTAMP_EN adds a free-running capture timestamp to every stored entry.
module acker_data_access
    import acker_pkg::*;
#(
    parameter int DEPTH_LOG2 = ACKER_DEPTH_LOG2,
    parameter int DATA_W     = ACKER_DATA_W,
    parameter int TS_W       = ACKER_TS_W
) (
    input  logic               clock,
    input  logic               reset,
    acker_data_access_if.slave bus
);
    localparam int EW = entry_w(DATA_W, TS_W);
    localparam logic [DEPTH_LOG2:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_count;
    logic [15:0]           r_discard;
    logic                  r_rd_valid;
    logic                  r_rd_underflow;

    logic          w_ready;
    logic          w_empty;
    logic          w_accept;
    logic          w_keep;
    logic          w_store;
    logic          w_discard;
    logic          w_pop;
    logic          w_underflow;
    logic [EW-1:0] w_wr_entry;
    logic [EW-1:0] w_rd_entry;

    // Ready depends on registered count only, so a same-cycle pop never opens the door.
    assign w_ready     = (r_count != FULL_CNT);
    assign w_empty     = (r_count == '0);
    assign w_accept    = bus.da_Data_in_valid & w_ready;
    assign w_keep      = bus.sensor_mask[bus.da_sensor_type];
    assign w_store     = w_accept & w_keep & ~bus.flush;
    assign w_discard   = w_accept & ~w_keep;
    assign w_pop       = bus.rd_req & ~w_empty & ~bus.flush;
    assign w_underflow = bus.rd_req & w_empty & ~bus.flush;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_count        <= '0;
            r_rd_valid     <= 1'b0;
            r_rd_underflow <= 1'b0;
        end else begin
            r_rd_valid     <= w_pop;
            r_rd_underflow <= w_underflow;
            if (bus.flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_store) begin
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                end
                case ({w_store, w_pop})
                    2'b10:   r_count <= r_count + 1'b1;
                    2'b01:   r_count <= r_count - 1'b1;
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    // Discards are counted even in a flush cycle; flush only clears FIFO state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_discard <= '0;
        end else if (w_discard && (r_discard != 16'hFFFF)) begin
            r_discard <= r_discard + 1'b1;
        end
    end

`ifdef ACKER_TIMESTAMP_EN
    logic [TS_W-1:0] r_ts;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_ts <= '0;
        end else begin
            r_ts <= r_ts + 1'b1;
        end
    end

    assign w_wr_entry       = {bus.da_sensor_type, bus.da_Data_in, r_ts};
    assign bus.rd_timestamp = w_rd_entry[TS_W-1:0];
    assign bus.rd_data      = w_rd_entry[TS_W +: DATA_W];
`else
    assign w_wr_entry       = {bus.da_sensor_type, bus.da_Data_in};
    assign bus.rd_timestamp = {TS_W{1'b0}};
    assign bus.rd_data      = w_rd_entry[DATA_W-1:0];
`endif

    acker_fifo_mem #(
        .WIDTH      (EW),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_mem (
        .clock     (clock),
        .reset     (reset),
        .i_wr_en   (w_store),
        .i_wr_addr (r_wr_ptr),
        .i_wr_dat  (w_wr_entry),
        .i_rd_en   (w_pop),
        .i_rd_addr (r_rd_ptr),
        .o_rd_dat  (w_rd_entry)
    );

    assign bus.rd_sensor            = w_rd_entry[EW-1 -: ACKER_SENSOR_W];
    assign bus.da_Ready_for_Data_in = w_ready;
    assign bus.rd_valid             = r_rd_valid;
    assign bus.rd_underflow         = r_rd_underflow;
    assign bus.fill_level           = r_count;
    assign bus.discard_count        = r_discard;
endmodule

// File: tb/tb_acker_data_access.sv
// Directed stimulus with a response queue checked by an independent monitor on the falling edge.
module tb_acker_data_access;
    import acker_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   cyc;
    int   n_total = 0;
    int   n_bad   = 0;

    typedef struct {
        bit          uf;
        logic [13:0] data;
        logic [1:0]  sensor;
        bit          chk_ts;
        logic [15:0] ts;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];

    acker_data_access_if #(.DATA_W(14), .DEPTH_LOG2(4), .TS_W(16)) bus ();

    acker_data_access #(.DEPTH_LOG2(4), .DATA_W(14), .TS_W(16)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // Mirrors the free-running timestamp: both start at 0 when reset releases.
    always @(posedge clock or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wr(input logic [13:0] d, input logic [1:0] s);
        bus.da_Data_in       = d;
        bus.da_sensor_type   = s;
        bus.da_Data_in_valid = 1'b1;
        tick();
        bus.da_Data_in_valid = 1'b0;
    endtask

    task automatic rd(input bit uf, input logic [13:0] d, input logic [1:0] s,
                      input bit chk_ts, input logic [15:0] ts);
        exp_t e;
        e.uf = uf; e.data = d; e.sensor = s; e.chk_ts = chk_ts; e.ts = ts; e.cyc = cyc + 1;
        exp_q.push_back(e);
        bus.rd_req = 1'b1;
        tick();
        bus.rd_req = 1'b0;
    endtask

    always @(negedge clock) begin
        exp_t e;
        bit   ok;
        if (!reset && (bus.rd_valid || bus.rd_underflow)) begin
            n_total++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL rd_unexpected: got valid=%0b underflow=%0b at cyc %0d, want no response",
                         bus.rd_valid, bus.rd_underflow, cyc);
            end else begin
                e  = exp_q.pop_front();
                ok = ({bus.rd_valid, bus.rd_underflow} == {!e.uf, e.uf}) && (cyc == e.cyc);
                if (!e.uf) ok = ok && (bus.rd_data == e.data) && (bus.rd_sensor == e.sensor);
                if (e.chk_ts) ok = ok && (bus.rd_timestamp == e.ts);
                if (!ok) begin
                    n_bad++;
                    $display("FAIL rd_resp: got valid=%0b uf=%0b cyc=%0d data=%0d sensor=%0d ts=%0d, want uf=%0b cyc=%0d data=%0d sensor=%0d ts=%0d",
                             bus.rd_valid, bus.rd_underflow, cyc, bus.rd_data, bus.rd_sensor,
                             bus.rd_timestamp, e.uf, e.cyc, e.data, e.sensor, e.ts);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, want finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] ts_a, ts_b;
        bus.da_Data_in       = '0;
        bus.da_Data_in_valid = 1'b0;
        bus.da_sensor_type   = SENSOR_0;
        bus.sensor_mask      = 4'b1111;
        bus.flush            = 1'b0;
        bus.rd_req           = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        tick();

        check("rst_ready", bus.da_Ready_for_Data_in, 1);
        check("rst_fill", bus.fill_level, 0);
        check("rst_discard", bus.discard_count, 0);
        check("rst_rd_valid", bus.rd_valid, 0);
        check("rst_rd_data", bus.rd_data, 0);
        check("rst_rd_ts", bus.rd_timestamp, 0);
        rd(1, 0, SENSOR_0, 0, 0);
        tick();

        // Fill to capacity
        for (int i = 0; i < 16; i++) wr(14'(i), 2'(i));
        check("full_fill", bus.fill_level, 16);
        check("full_ready", bus.da_Ready_for_Data_in, 0);
        bus.da_Data_in = 14'd99;
        bus.da_Data_in_valid = 1'b1;
        tick();
        check("full_hold_fill", bus.fill_level, 16);
        // Full + read + valid: pop happens, the held sample is not written
        rd(0, 14'd0, SENSOR_0, 0, 0);
        bus.da_Data_in_valid = 1'b0;
        check("full_pop_fill", bus.fill_level, 15);
        check("full_pop_ready", bus.da_Ready_for_Data_in, 1);
        for (int i = 1; i < 16; i++) rd(0, 14'(i), 2'(i), 0, 0);
        tick();
        tick();
        check("drain_fill", bus.fill_level, 0);
        check("hold_rd_data", bus.rd_data, 15);
        check("hold_rd_sensor", bus.rd_sensor, 3);

        // Masking
        bus.sensor_mask = 4'b0101;
        for (int i = 0; i < 4; i++) wr(14'(100 + i), 2'(i));
        check("mask_fill", bus.fill_level, 2);
        check("mask_discard", bus.discard_count, 2);
        rd(0, 14'd100, SENSOR_0, 0, 0);
        rd(0, 14'd102, SENSOR_2, 0, 0);
        bus.sensor_mask = 4'b1111;

        // Simultaneous write and read at fill 5
        for (int i = 0; i < 5; i++) wr(14'(200 + i), 2'(i));
        check("sim_pre_fill", bus.fill_level, 5);
        bus.da_Data_in = 14'd205;
        bus.da_sensor_type = SENSOR_1;
        bus.da_Data_in_valid = 1'b1;
        rd(0, 14'd200, SENSOR_0, 0, 0);
        bus.da_Data_in_valid = 1'b0;
        check("sim_fill", bus.fill_level, 5);
        for (int i = 1; i < 5; i++) rd(0, 14'(200 + i), 2'(i), 0, 0);
        rd(0, 14'd205, SENSOR_1, 0, 0);

        // Flush with write and read at fill 3
        for (int i = 0; i < 3; i++) wr(14'(300 + i), SENSOR_2);
        check("flush_pre_fill", bus.fill_level, 3);
        bus.flush = 1'b1;
        bus.rd_req = 1'b1;
        bus.da_Data_in = 14'd303;
        bus.da_Data_in_valid = 1'b1;
        tick();
        bus.flush = 1'b0;
        bus.rd_req = 1'b0;
        bus.da_Data_in_valid = 1'b0;
        check("flush_fill", bus.fill_level, 0);
        check("flush_discard", bus.discard_count, 2);
        tick();
        tick();
        rd(1, 0, SENSOR_0, 0, 0);

        // Empty: write lands while the same-cycle read underflows
        bus.da_Data_in = 14'd400;
        bus.da_sensor_type = SENSOR_3;
        bus.da_Data_in_valid = 1'b1;
        rd(1, 0, SENSOR_0, 0, 0);
        bus.da_Data_in_valid = 1'b0;
        check("empty_wr_fill", bus.fill_level, 1);
        rd(0, 14'd400, SENSOR_3, 0, 0);
        tick();

        // Reset mid-operation
        wr(14'd500, SENSOR_0);
        wr(14'd501, SENSOR_1);
        reset = 1'b1;
        #1;
        check("arst_fill", bus.fill_level, 0);
        check("arst_rd_data", bus.rd_data, 0);
        check("arst_discard", bus.discard_count, 0);
        tick();
        reset = 1'b0;

        // Timestamps captured at cycles 10 and 13 after reset
`ifdef ACKER_TIMESTAMP_EN
        ts_a = 16'd10;
        ts_b = 16'd13;
`else
        ts_a = 16'd0;
        ts_b = 16'd0;
`endif
        while (cyc != 10) tick();
        wr(14'd600, SENSOR_2);
        while (cyc != 13) tick();
        wr(14'd601, SENSOR_1);
        check("ts_fill", bus.fill_level, 2);
        rd(0, 14'd600, SENSOR_2, 1, ts_a);
        rd(0, 14'd601, SENSOR_1, 1, ts_b);
        repeat (3) tick();

        check("resp_pending", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
